// File: rtl/video_sig_gen.sv
// Raster timing generator for a TMDS transmitter.
// It produces the pixel position, the sync strobes, the active-draw strobe and
// the frame-boundary pulse and counter. Every output is registered and
// describes the position presented in the same cycle. Each output register is
// loaded from the next-position logic, so the outputs have no extra latency.
// Handshake: none. The generator free-runs on every clock edge with rst_in=0.
module video_sig_gen #(
    parameter int  ACTIVE_H = 1280,
    parameter int  H_FP     = 110,
    parameter int  H_SYNC   = 40,
    parameter int  H_BP     = 220,
    parameter int  ACTIVE_V = 720,
    parameter int  V_FP     = 5,
    parameter int  V_SYNC   = 5,
    parameter int  V_BP     = 20,
    parameter int  FPS      = 60,
    localparam int TOTAL_H  = ACTIVE_H + H_FP + H_SYNC + H_BP,
    localparam int TOTAL_V  = ACTIVE_V + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(TOTAL_H),
    localparam int VW       = $clog2(TOTAL_V),
    localparam int FW       = $clog2(FPS)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [FW-1:0] fc_out,
    output logic [3:0]    dbg_state_out   // {vertical phase, horizontal phase}
);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    // Phase thresholds at full counter width, so no comparison truncates.
    localparam logic [HW-1:0] H_LAST  = HW'(TOTAL_H - 1);
    localparam logic [HW-1:0] H_FP_AT = HW'(ACTIVE_H);
    localparam logic [HW-1:0] H_SY_AT = HW'(ACTIVE_H + H_FP);
    localparam logic [HW-1:0] H_BP_AT = HW'(ACTIVE_H + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(TOTAL_V - 1);
    localparam logic [VW-1:0] V_FP_AT = VW'(ACTIVE_V);
    localparam logic [VW-1:0] V_SY_AT = VW'(ACTIVE_V + V_FP);
    localparam logic [VW-1:0] V_BP_AT = VW'(ACTIVE_V + V_FP + V_SYNC);
    localparam logic [FW-1:0] F_LAST  = FW'(FPS - 1);

    logic [HW-1:0] r_hpos;
    logic [VW-1:0] r_vpos;
    phase_t        r_hstate;
    phase_t        r_vstate;
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic          r_hs;
    logic          r_vs;
    logic          r_ad;
    logic          r_nf;
    logic [FW-1:0] r_fc;

    logic [HW-1:0] w_hpos_nxt;
    logic [VW-1:0] w_vpos_nxt;
    logic          w_hwrap;
    phase_t        w_hstate_nxt;
    phase_t        w_vstate_nxt;
    logic          w_ad_nxt;
    logic          w_nf_nxt;

    // Next raster position: h wraps at the line end, v advances only on that wrap.
    always_comb begin
        w_hwrap    = (r_hpos == H_LAST);
        w_hpos_nxt = w_hwrap ? '0 : r_hpos + HW'(1);
        w_vpos_nxt = r_vpos;
        if (w_hwrap) begin
            w_vpos_nxt = (r_vpos == V_LAST) ? '0 : r_vpos + VW'(1);
        end
    end

    // Phase FSM next state for both axes, keyed on the position about to be shown.
    always_comb begin
        w_hstate_nxt = r_hstate;
        w_vstate_nxt = r_vstate;
        case (r_hstate)
            PH_ACTIVE: if (w_hpos_nxt == H_FP_AT) w_hstate_nxt = PH_FP;
            PH_FP:     if (w_hpos_nxt == H_SY_AT) w_hstate_nxt = PH_SYNC;
            PH_SYNC:   if (w_hpos_nxt == H_BP_AT) w_hstate_nxt = PH_BP;
            PH_BP:     if (w_hpos_nxt == '0)      w_hstate_nxt = PH_ACTIVE;
            default:   w_hstate_nxt = PH_ACTIVE;
        endcase
        // The vertical phase only moves at a line boundary so vsync spans whole lines.
        if (w_hwrap) begin
            case (r_vstate)
                PH_ACTIVE: if (w_vpos_nxt == V_FP_AT) w_vstate_nxt = PH_FP;
                PH_FP:     if (w_vpos_nxt == V_SY_AT) w_vstate_nxt = PH_SYNC;
                PH_SYNC:   if (w_vpos_nxt == V_BP_AT) w_vstate_nxt = PH_BP;
                PH_BP:     if (w_vpos_nxt == '0)      w_vstate_nxt = PH_ACTIVE;
                default:   w_vstate_nxt = PH_ACTIVE;
            endcase
        end
        w_ad_nxt = (w_hpos_nxt < H_FP_AT) && (w_vpos_nxt < V_FP_AT);
        w_nf_nxt = (w_hpos_nxt == H_FP_AT) && (w_vpos_nxt == V_FP_AT);
    end

    // State and position registers. Reset parks the position on the last pixel
    // so that the first free-running edge lands on (0,0).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hpos   <= H_LAST;
            r_vpos   <= V_LAST;
            r_hstate <= PH_BP;
            r_vstate <= PH_BP;
        end else begin
            r_hpos   <= w_hpos_nxt;
            r_vpos   <= w_vpos_nxt;
            r_hstate <= w_hstate_nxt;
            r_vstate <= w_vstate_nxt;
        end
    end

    // Output registers, loaded from next-position decode so they align with the count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_ad     <= 1'b0;
            r_nf     <= 1'b0;
            r_fc     <= '0;
        end else begin
            r_hcount <= w_hpos_nxt;
            r_vcount <= w_vpos_nxt;
            r_hs     <= (w_hstate_nxt == PH_SYNC);
            r_vs     <= (w_vstate_nxt == PH_SYNC);
            r_ad     <= w_ad_nxt;
            r_nf     <= w_nf_nxt;
            if (w_nf_nxt) begin
                r_fc <= (r_fc == F_LAST) ? '0 : r_fc + FW'(1);
            end
        end
    end

    assign hcount_out    = r_hcount;
    assign vcount_out    = r_vcount;
    assign hs_out        = r_hs;
    assign vs_out        = r_vs;
    assign ad_out        = r_ad;
    assign nf_out        = r_nf;
    assign fc_out        = r_fc;
    assign dbg_state_out = {r_vstate, r_hstate};

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench for video_sig_gen. It uses three instances:
//   d: default 1280x720 timing (reset, line timing, mid-frame reset)
//   s: 4x2 raster with 1-wide porches/syncs, FPS=2 (exhaustive golden sequence)
//   f: the same small raster with FPS=60 (frame counter over 61 frames)
// Outputs are sampled on the falling edge. Inputs change right after sampling.
module tb_video_sig_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    logic rst_f = 1'b1;

    // ---------------- DUT instances ----------------
    logic [10:0] d_h;
    logic [9:0]  d_v;
    logic        d_hs, d_vs, d_ad, d_nf;
    logic [5:0]  d_fc;
    logic [3:0]  d_dbg;

    logic [2:0]  s_h, s_v;
    logic        s_hs, s_vs, s_ad, s_nf;
    logic [0:0]  s_fc;
    logic [3:0]  s_dbg;

    logic [2:0]  f_h, f_v;
    logic        f_hs, f_vs, f_ad, f_nf;
    logic [5:0]  f_fc;
    logic [3:0]  f_dbg;

    video_sig_gen u_d (
        .clk_in(clk), .rst_in(rst_d), .hcount_out(d_h), .vcount_out(d_v),
        .hs_out(d_hs), .vs_out(d_vs), .ad_out(d_ad), .nf_out(d_nf),
        .fc_out(d_fc), .dbg_state_out(d_dbg)
    );

    video_sig_gen #(
        .ACTIVE_H(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .ACTIVE_V(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FPS(2)
    ) u_s (
        .clk_in(clk), .rst_in(rst_s), .hcount_out(s_h), .vcount_out(s_v),
        .hs_out(s_hs), .vs_out(s_vs), .ad_out(s_ad), .nf_out(s_nf),
        .fc_out(s_fc), .dbg_state_out(s_dbg)
    );

    video_sig_gen #(
        .ACTIVE_H(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .ACTIVE_V(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FPS(60)
    ) u_f (
        .clk_in(clk), .rst_in(rst_f), .hcount_out(f_h), .vcount_out(f_v),
        .hs_out(f_hs), .vs_out(f_vs), .ad_out(f_ad), .nf_out(f_nf),
        .fc_out(f_fc), .dbg_state_out(f_dbg)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Small-raster golden model: 7 pixels x 5 lines, FPS=2.
    int m_h, m_v, m_fc, cyc, last_nf, nf_cnt;

    function automatic int sm_phase(input int p, input int a);
        // Phase code for a 1-wide porch/sync raster with a active units.
        if (p < a)          return 0;
        else if (p == a)    return 1;
        else if (p == a + 1) return 2;
        else                return 3;
    endfunction

    task automatic small_step();
        int exp_dbg;
        @(negedge clk);
        if (m_h == 4 && m_v == 2) m_fc = (m_fc + 1) % 2;
        exp_dbg = sm_phase(m_v, 2) * 4 + sm_phase(m_h, 4);
        chk("s_h",   s_h,   m_h);
        chk("s_v",   s_v,   m_v);
        chk("s_hs",  s_hs,  (m_h == 5));
        chk("s_vs",  s_vs,  (m_v == 3));
        chk("s_ad",  s_ad,  (m_h < 4 && m_v < 2));
        chk("s_nf",  s_nf,  (m_h == 4 && m_v == 2));
        chk("s_fc",  s_fc,  m_fc);
        chk("s_dbg", s_dbg, exp_dbg);
        if (s_nf === 1'b1) begin
            if (last_nf >= 0) chk("s_nf_period", cyc - last_nf, 35);
            last_nf = cyc;
            nf_cnt++;
        end
        cyc++;
        m_h++;
        if (m_h == 7) begin
            m_h = 0;
            m_v = (m_v + 1) % 5;
        end
    endtask

    // Default-timing model: 1650 x 750.
    int dm_h, dm_v;
    int hs_cnt, hs_first, ad_fall;

    task automatic default_step();
        @(negedge clk);
        chk("d_h",  d_h,  dm_h);
        chk("d_v",  d_v,  dm_v);
        chk("d_ad", d_ad, (dm_h < 1280 && dm_v < 720));
        chk("d_hs", d_hs, (dm_h >= 1390 && dm_h < 1430));
        chk("d_vs", d_vs, (dm_v >= 725 && dm_v < 730));
        chk("d_nf", d_nf, (dm_h == 1280 && dm_v == 720));
        chk("d_fc", d_fc, 0);
        if (dm_v == 0 && d_hs === 1'b1) begin
            if (hs_cnt == 0) hs_first = dm_h;
            hs_cnt++;
        end
        if (dm_v == 0 && d_ad === 1'b0 && ad_fall < 0) ad_fall = dm_h;
        dm_h++;
        if (dm_h == 1650) begin
            dm_h = 0;
            dm_v = (dm_v + 1) % 750;
        end
    endtask

    // ---------------- stimulus ----------------
    int fm_h, fm_v, fm_fc, f_prev;
    bit saw59, wrapped;

    initial begin
        // Reset: 3 cycles with every output held at 0; the phase state parks on BP/BP.
        repeat (3) begin
            @(negedge clk);
            chk("s_rst_h",   s_h,   0);
            chk("s_rst_v",   s_v,   0);
            chk("s_rst_hs",  s_hs,  0);
            chk("s_rst_vs",  s_vs,  0);
            chk("s_rst_ad",  s_ad,  0);
            chk("s_rst_nf",  s_nf,  0);
            chk("s_rst_fc",  s_fc,  0);
            chk("s_rst_dbg", s_dbg, 4'hF);
            chk("d_rst_h",   d_h,   0);
            chk("d_rst_v",   d_v,   0);
            chk("d_rst_ad",  d_ad,  0);
            chk("d_rst_hs",  d_hs,  0);
            chk("d_rst_fc",  d_fc,  0);
        end

        // Small raster: 3 frames exhaustively against the golden model.
        rst_s = 1'b0;
        m_h = 0; m_v = 0; m_fc = 0; cyc = 0; last_nf = -1; nf_cnt = 0;
        repeat (105) small_step();
        chk("s_nf_count", nf_cnt, 3);

        // Mid-frame reset at (2,1), with fc=1 beforehand.
        while (!(m_h == 2 && m_v == 1)) small_step();
        small_step();
        rst_s = 1'b1;
        @(negedge clk);
        chk("s_mid_h",  s_h,  0);
        chk("s_mid_v",  s_v,  0);
        chk("s_mid_ad", s_ad, 0);
        chk("s_mid_fc", s_fc, 0);
        rst_s = 1'b0;
        m_h = 0; m_v = 0; m_fc = 0; last_nf = -1;
        repeat (40) small_step();

        // Frame counter over 61 frames with FPS=60.
        rst_f = 1'b0;
        fm_h = 0; fm_v = 0; fm_fc = 0; f_prev = 0; saw59 = 0; wrapped = 0;
        repeat (61 * 35) begin
            @(negedge clk);
            if (fm_h == 4 && fm_v == 2) fm_fc = (fm_fc + 1) % 60;
            chk("f_h",  f_h,  fm_h);
            chk("f_v",  f_v,  fm_v);
            chk("f_nf", f_nf, (fm_h == 4 && fm_v == 2));
            chk("f_fc", f_fc, fm_fc);
            if (f_fc === 6'd59) saw59 = 1;
            if (f_prev == 59 && f_fc === 6'd0 && f_nf === 1'b1) wrapped = 1;
            f_prev = int'(f_fc);
            fm_h++;
            if (fm_h == 7) begin
                fm_h = 0;
                fm_v = (fm_v + 1) % 5;
            end
        end
        chk("f_saw59", saw59, 1);
        chk("f_wrap",  wrapped, 1);

        // Default timing: three full lines.
        rst_d = 1'b0;
        dm_h = 0; dm_v = 0; hs_cnt = 0; hs_first = -1; ad_fall = -1;
        repeat (3 * 1650) default_step();
        chk("d_hs_width", hs_cnt, 40);
        chk("d_hs_first", hs_first, 1390);
        chk("d_ad_fall",  ad_fall, 1280);

        // Mid-frame reset at (500,3).
        while (!(dm_h == 500 && dm_v == 3)) default_step();
        default_step();
        rst_d = 1'b1;
        @(negedge clk);
        chk("d_mid_h",  d_h,  0);
        chk("d_mid_v",  d_v,  0);
        chk("d_mid_ad", d_ad, 0);
        chk("d_mid_hs", d_hs, 0);
        rst_d = 1'b0;
        dm_h = 0; dm_v = 0;
        repeat (1700) default_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
